// File: rtl/div_iter_if.sv
// Start/operand handshake between the EX stage and the iterative divider.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 div_zero_o;
  logic                 busy_o;

  // EX stage side
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, div_zero_o, busy_o
  );

  // divider side
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, div_zero_o, busy_o
  );
endinterface

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// Result is {remainder, quotient}; signed mode divides magnitudes and
// fixes signs on the last iteration.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start_i; operands latched on acceptance
// BYZERO | zero divisor seen; next cycle reports div_zero_o
// ON     | restoring iterations, cnt = iterations done so far
// END    | result valid, held until start_i drops
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_iter_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [WIDTH:0]       rem, rem_n;
  logic [WIDTH-1:0]     quo, quo_n;
  logic [WIDTH-1:0]     dvs, dvs_n;
  logic                 sgn_mode, sgn_mode_n;
  logic                 sgn_a, sgn_a_n;
  logic                 sgn_b, sgn_b_n;
  logic [2*WIDTH-1:0]   result, result_n;
  logic                 ready, ready_n;
  logic                 divz, divz_n;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       shifted, diff, rem_step;
  logic [WIDTH-1:0]     quo_step, q_fix, r_fix;

  // One restoring step plus the sign fix applied to its outcome. The
  // magnitude of the most negative value is representable unsigned, so
  // -2^(WIDTH-1) / -1 naturally wraps back to -2^(WIDTH-1).
  always_comb begin
    a_mag    = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    b_mag    = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
    shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff     = shifted - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_step = diff;
      quo_step = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = shifted;
      quo_step = {quo[WIDTH-2:0], 1'b0};
    end
    q_fix = (sgn_mode && (sgn_a ^ sgn_b)) ? -quo_step : quo_step;
    r_fix = (sgn_mode && sgn_a) ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
  end

  // Next-state and next-register values; annul_i overrides everything.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rem_n      = rem;
    quo_n      = quo;
    dvs_n      = dvs;
    sgn_mode_n = sgn_mode;
    sgn_a_n    = sgn_a;
    sgn_b_n    = sgn_b;
    result_n   = result;
    ready_n    = ready;
    divz_n     = divz;

    case (state)
      IDLE: begin
        if (bus.start_i) begin
          sgn_mode_n = bus.signed_div_i;
          sgn_a_n    = bus.opdata1_i[WIDTH-1];
          sgn_b_n    = bus.opdata2_i[WIDTH-1];
          quo_n      = a_mag;
          dvs_n      = b_mag;
          rem_n      = '0;
          cnt_n      = '0;
          state_n    = (bus.opdata2_i == '0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        state_n  = END;
        result_n = '0;
        ready_n  = 1'b1;
        divz_n   = 1'b1;
      end
      ON: begin
        rem_n = rem_step;
        quo_n = quo_step;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_n  = END;
          result_n = {r_fix, q_fix};
          ready_n  = 1'b1;
          divz_n   = 1'b0;
        end
      end
      END: begin
        if (!bus.start_i) begin
          state_n  = IDLE;
          result_n = '0;
          ready_n  = 1'b0;
          divz_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (bus.annul_i) begin
      state_n  = IDLE;
      cnt_n    = '0;
      result_n = '0;
      ready_n  = 1'b0;
      divz_n   = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      sgn_mode <= 1'b0;
      sgn_a    <= 1'b0;
      sgn_b    <= 1'b0;
      result   <= '0;
      ready    <= 1'b0;
      divz     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rem      <= rem_n;
      quo      <= quo_n;
      dvs      <= dvs_n;
      sgn_mode <= sgn_mode_n;
      sgn_a    <= sgn_a_n;
      sgn_b    <= sgn_b_n;
      result   <= result_n;
      ready    <= ready_n;
      divz     <= divz_n;
    end
  end

  assign bus.result_o   = result;
  assign bus.ready_o    = ready;
  assign bus.div_zero_o = divz;
  assign bus.busy_o     = (state != IDLE);

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: a 32-bit and an 8-bit instance share one clock.
module tb_div_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  div_iter_if #(.WIDTH(32)) bus32();
  div_iter_if #(.WIDTH(8))  bus8();

  div_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  div_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one 32-bit operation, scramble inputs after acceptance, wait for
  // ready, then verify hold-while-start and clear-after-start-drop.
  task automatic run32(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp_res,
                       input logic exp_dz, input int exp_cyc);
    int cyc;
    bus32.signed_div_i = sgn;
    bus32.opdata1_i    = a;
    bus32.opdata2_i    = b;
    bus32.start_i      = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({tag, "_busy"}, 128'(bus32.busy_o), 128'(1));
        bus32.opdata1_i    = ~a;
        bus32.opdata2_i    = 32'h3;
        bus32.signed_div_i = ~sgn;
      end
    end while (!bus32.ready_o && cyc < 200);
    check({tag, "_latency"}, 128'(cyc), 128'(exp_cyc));
    check({tag, "_result"}, 128'(bus32.result_o), 128'(exp_res));
    check({tag, "_dz"}, 128'(bus32.div_zero_o), 128'(exp_dz));
    repeat (2) @(negedge clk);
    check({tag, "_hold"}, 128'({bus32.ready_o, bus32.result_o}), 128'({1'b1, exp_res}));
    bus32.start_i = 1'b0;
    @(negedge clk);
    check({tag, "_clear"},
          128'({bus32.ready_o, bus32.div_zero_o, bus32.busy_o, bus32.result_o}), 128'(0));
  endtask

  task automatic run8(input string tag, input logic sgn, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp_res, input int exp_cyc);
    int cyc;
    bus8.signed_div_i = sgn;
    bus8.opdata1_i    = a;
    bus8.opdata2_i    = b;
    bus8.start_i      = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus8.ready_o && cyc < 100);
    check({tag, "_latency"}, 128'(cyc), 128'(exp_cyc));
    check({tag, "_result"}, 128'({bus8.div_zero_o, bus8.result_o}), 128'({1'b0, exp_res}));
    bus8.start_i = 1'b0;
    @(negedge clk);
    check({tag, "_clear"}, 128'({bus8.ready_o, bus8.busy_o, bus8.result_o}), 128'(0));
  endtask

  initial begin
    logic saw_ready;
    bus32.signed_div_i = 1'b0; bus32.opdata1_i = '0; bus32.opdata2_i = '0;
    bus32.start_i = 1'b0; bus32.annul_i = 1'b0;
    bus8.signed_div_i = 1'b0; bus8.opdata1_i = '0; bus8.opdata2_i = '0;
    bus8.start_i = 1'b0; bus8.annul_i = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset32", 128'({bus32.ready_o, bus32.div_zero_o, bus32.busy_o, bus32.result_o}), 128'(0));
    check("reset8", 128'({bus8.ready_o, bus8.div_zero_o, bus8.busy_o, bus8.result_o}), 128'(0));

    run32("u100_7",  1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                1'b0, 33);
    run32("s_m7_2",  1'b1, 32'hFFFFFFF9,   32'h2,          {32'hFFFFFFFF, 32'hFFFFFFFD},   1'b0, 33);
    run32("s_7_m2",  1'b1, 32'd7,          32'hFFFFFFFE,   {32'h1, 32'hFFFFFFFD},          1'b0, 33);
    run32("s_ovf",   1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0, 32'h80000000},          1'b0, 33);
    run32("u_ovf",   1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'h0},          1'b0, 33);
    run32("byzero",  1'b0, 32'h1234,       32'h0,          64'h0,                          1'b1, 2);

    // annul ten cycles into ON
    bus32.signed_div_i = 1'b0; bus32.opdata1_i = 32'd100; bus32.opdata2_i = 32'd7;
    bus32.start_i = 1'b1;
    repeat (11) @(negedge clk);
    bus32.annul_i = 1'b1;
    bus32.start_i = 1'b0;
    @(negedge clk);
    bus32.annul_i = 1'b0;
    check("annul_idle", 128'({bus32.busy_o, bus32.ready_o, bus32.result_o}), 128'(0));
    saw_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.ready_o) saw_ready = 1'b1;
    end
    check("annul_no_ready", 128'(saw_ready), 128'(0));
    run32("annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 33);

    // reset ten cycles into ON
    bus32.opdata1_i = 32'd100; bus32.opdata2_i = 32'd7;
    bus32.start_i = 1'b1;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    bus32.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_idle", 128'({bus32.busy_o, bus32.ready_o, bus32.result_o}), 128'(0));
    saw_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.ready_o) saw_ready = 1'b1;
    end
    check("rst_no_ready", 128'(saw_ready), 128'(0));
    run32("rst_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 33);

    run8("u200_3",  1'b0, 8'd200, 8'd3,  {8'd2, 8'd66},    9);
    run8("s80_3",   1'b1, 8'h80,  8'h03, {8'hFE, 8'hD6},   9);
    run8("u5_9",    1'b0, 8'd5,   8'd9,  {8'd5, 8'd0},     9);
    run8("s80_ff",  1'b1, 8'h80,  8'hFF, {8'h00, 8'h80},   9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative divider for the CPU execute stage. It supersedes the fixed 32-bit divider and adds configurable operand width, a divide-by-zero flag, a busy indication and a defined result for signed overflow. The EX stage drives the start/operand handshake and stalls the pipeline until `ready_o`. The pipeline flush drives `annul_i`. The 2×WIDTH result is written to HI/LO as {remainder, quotient}.

## Interface
- WIDTH, 32: operand width in bits; legal values 4..64.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- signed_div_i  input  1  1 = two's-complement divide, 0 = unsigned.
- opdata1_i  input  WIDTH  dividend; sampled only on the accepting cycle.
- opdata2_i  input  WIDTH  divisor; sampled only on the accepting cycle.
- start_i  input  1  request; held high by EX until it has consumed `ready_o`.
- annul_i  input  1  abort, driven by the pipeline flush.
- result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; registered.
- ready_o  output  1  result valid; registered.
- div_zero_o  output  1  current result came from a zero divisor; registered.
- busy_o  output  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, BYZERO, ON, END. Encoding is free.
- IDLE
  - start_i=1 and annul_i=0 with divisor==0: go to BYZERO.
  - start_i=1 and annul_i=0 with divisor!=0: go to ON.
  - In both cases, latch signed_div_i, the operand sign bits, and magnitudes. Magnitude is the absolute value when signed, else the raw value. Clear cnt.
- BYZERO: go to END with result=0 and div_zero_o=1.
- ON: restoring division on magnitudes, one quotient bit per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits: shift left, bring in the next dividend bit, subtract the divisor.
  - Non-negative difference: quotient bit 1 and keep the difference. Otherwise quotient bit 0 and keep the shifted value.
  - cnt increments each cycle. After WIDTH iterations, go to END.
- On the ON→END transition, apply the sign fix (signed mode only):
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - Then register result_o, set ready_o=1, div_zero_o=0.
- END
  - Hold result_o, ready_o and div_zero_o while start_i=1.
  - start_i=0: go to IDLE, clear ready_o, result_o and div_zero_o.
- annul_i=1 in any state: next state IDLE, all outputs 0. annul_i has priority over start_i and over completion in the same cycle.
- Arithmetic rules:
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), computed unsigned.
  - Signed -2^(WIDTH-1) / -1 gives quotient -2^(WIDTH-1) (wraps) and remainder 0. No flag is raised.
  - A dividend smaller than the divisor gives quotient 0 and remainder = dividend.
- Changes to operands or signed_div_i after acceptance have no effect.
- start_i while busy is ignored; there is no queueing.

## Timing
- Reset: state IDLE, cnt 0; result_o=0, ready_o=0, div_zero_o=0, busy_o=0. Reset overrides annul and start, including mid-divide.
- Non-zero divisor accepted at edge t:
  - busy_o=1 from t.
  - ON occupies cycles t..t+WIDTH-1.
  - ready_o=1 from t+WIDTH.
  - Latency is WIDTH+1 cycles from the cycle start_i is first high in IDLE to the first ready_o cycle (33 for WIDTH=32).
- Zero divisor: ready_o=1 and div_zero_o=1 two cycles after the accepting cycle.
- ready_o stays high until the cycle after start_i falls. Back-to-back operations need at least one start_i-low cycle (END→IDLE) between them.
- busy_o is combinational from state; all other outputs are registered.

## Test plan
- WIDTH=32, unsigned 100/7 → after 33 cycles ready_o=1, result_o={32'd2, 32'd14}, div_zero_o=0. ready_o stays high while start_i=1 and clears one cycle after start_i drops.
- WIDTH=32, signed -7/2 (0xFFFFFFF9 / 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 → quotient 0xFFFFFFFD, remainder 0x1.
- WIDTH=32, signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned with the same operands → quotient 0, remainder 0x80000000.
- Divisor 0 with dividend 0x1234 → ready_o=1 on the 2nd cycle after acceptance, result_o=0, div_zero_o=1.
- Annul and reset mid-operation:
  - annul_i pulsed 10 cycles into ON → next cycle IDLE, busy_o=0, ready_o never asserts. A new 9/3 request then completes normally with quotient 3, remainder 0.
  - rst asserted mid-ON gives the same result.
- WIDTH=8 instance, unsigned 200/3 → ready after 9 cycles, result_o={8'd2, 8'd66}. Signed 0x80/0x03 → quotient 0xD6 (-42), remainder 0xFE (-2).
